// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared AHB/APB bridge encodings and error FSM state type
package bridge_pkg;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   localparam logic [2:0] SEL0 = 3'b001;
   localparam logic [2:0] SEL1 = 3'b010;
   localparam logic [2:0] SEL2 = 3'b100;

   typedef enum logic [1:0] {
      ERR_IDLE = 2'd0,
      ERR_1    = 2'd1,
      ERR_2    = 2'd2
   } err_state_e;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational one-hot peripheral select from AHB address
module ahb_addr_decode
   import bridge_pkg::*;
#(
   parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
   parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
   parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
   parameter int          REGION_LOG2 = 26
) (
   input  logic [31:0] i_addr,
   output logic [2:0]  o_sel,
   output logic        o_mapped
);

   logic w_hit0, w_hit1, w_hit2;

   assign w_hit0 = (i_addr[31:REGION_LOG2] == SLV0_BASE[31:REGION_LOG2]);
   assign w_hit1 = (i_addr[31:REGION_LOG2] == SLV1_BASE[31:REGION_LOG2]);
   assign w_hit2 = (i_addr[31:REGION_LOG2] == SLV2_BASE[31:REGION_LOG2]);

   assign o_sel    = (w_hit0 ? SEL0 : 3'b000) | (w_hit1 ? SEL1 : 3'b000) | (w_hit2 ? SEL2 : 3'b000);
   assign o_mapped = |o_sel;

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB slave front end: phase pipeline, decode, ERROR response FSM
module ahb_slave_if
   import bridge_pkg::*;
#(
   parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
   parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
   parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
   parameter int          REGION_LOG2 = 26,
   parameter int          ERRCNT_W    = 8
) (
   input  logic                Hclk,
   input  logic                Hreset,
   input  logic                Hwrite,
   input  logic                Hreadyin,
   input  logic [1:0]          Htrans,
   input  logic [31:0]         Haddr,
   input  logic [31:0]         Hwdata,
   input  logic [31:0]         Prdata,
   output logic                valid,
   output logic [31:0]         Haddr1,
   output logic [31:0]         Haddr2,
   output logic [31:0]         Hwdata1,
   output logic [31:0]         Hwdata2,
   output logic                Hwritereg,
   output logic [2:0]          tempselx,
   output logic [31:0]         Hrdata,
   output logic [1:0]          Hresp,
   output logic                err_stall,
   output logic [ERRCNT_W-1:0] err_count
);

   logic                w_active;
   logic                w_mapped;
   logic                w_err_entry;
   err_state_e          r_state;
   err_state_e          w_state_nxt;
   logic [31:0]         r_haddr1, r_haddr2, r_hwdata1, r_hwdata2;
   logic                r_hwritereg;
   logic [1:0]          r_hresp;
   logic                r_err_stall;
   logic [ERRCNT_W-1:0] r_err_count;

   ahb_addr_decode #(
      .SLV0_BASE   (SLV0_BASE),
      .SLV1_BASE   (SLV1_BASE),
      .SLV2_BASE   (SLV2_BASE),
      .REGION_LOG2 (REGION_LOG2)
   ) u_decode (
      .i_addr   (Haddr),
      .o_sel    (tempselx),
      .o_mapped (w_mapped)
   );

   assign w_active = Hreadyin && ((Htrans == HT_NONSEQ) || (Htrans == HT_SEQ));
   assign valid    = w_active && w_mapped && (r_state != ERR_1);
   assign Hrdata   = Prdata;

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         r_haddr1    <= '0;
         r_haddr2    <= '0;
         r_hwdata1   <= '0;
         r_hwdata2   <= '0;
         r_hwritereg <= 1'b0;
      end else if (Hreadyin) begin
         r_haddr1    <= Haddr;
         r_haddr2    <= r_haddr1;
         r_hwdata1   <= Hwdata;
         r_hwdata2   <= r_hwdata1;
         r_hwritereg <= Hwrite;
      end
   end

   // The phase sampled during ERR_1 is dropped, so only IDLE/ERR_2 can start an error.
   always_comb begin
      w_state_nxt = r_state;
      w_err_entry = 1'b0;
      case (r_state)
         ERR_IDLE: begin
            if (w_active && !w_mapped) begin
               w_state_nxt = ERR_1;
               w_err_entry = 1'b1;
            end
         end
         ERR_1: w_state_nxt = ERR_2;
         ERR_2: begin
            if (w_active && !w_mapped) begin
               w_state_nxt = ERR_1;
               w_err_entry = 1'b1;
            end else begin
               w_state_nxt = ERR_IDLE;
            end
         end
         default: w_state_nxt = ERR_IDLE;
      endcase
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         r_state     <= ERR_IDLE;
         r_hresp     <= RESP_OKAY;
         r_err_stall <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_hresp     <= (w_state_nxt == ERR_IDLE) ? RESP_OKAY : RESP_ERROR;
         r_err_stall <= (w_state_nxt == ERR_1);
         if (w_err_entry && (r_err_count != {ERRCNT_W{1'b1}}))
            r_err_count <= r_err_count + 1'b1;
      end
   end

   assign Haddr1    = r_haddr1;
   assign Haddr2    = r_haddr2;
   assign Hwdata1   = r_hwdata1;
   assign Hwdata2   = r_hwdata2;
   assign Hwritereg = r_hwritereg;
   assign Hresp     = r_hresp;
   assign err_stall = r_err_stall;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - randomized self-checking bench for ahb_slave_if against a reference model
module tb_ahb_slave_if;

   logic        Hclk = 1'b0;
   logic        Hreset, Hwrite, Hreadyin;
   logic [1:0]  Htrans;
   logic [31:0] Haddr, Hwdata, Prdata;
   logic        valid, Hwritereg, err_stall;
   logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
   logic [2:0]  tempselx;
   logic [1:0]  Hresp;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: error response age (0 none, 1 first cycle, 2 second cycle) and pipeline history.
   int          m_err_age = 0;
   int          m_cnt = 0;
   logic [31:0] m_a1 = 0, m_a2 = 0, m_d1 = 0, m_d2 = 0;
   logic        m_w = 0;
   bit          m_known = 0;

   always #5 Hclk = ~Hclk;

   ahb_slave_if dut (
      .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
      .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
      .valid(valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
      .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .tempselx(tempselx),
      .Hrdata(Hrdata), .Hresp(Hresp), .err_stall(err_stall), .err_count(err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] exp_sel(input logic [31:0] a);
      if (a >= 32'h8000_0000 && a < 32'h8C00_0000)
         return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
      return 3'b000;
   endfunction

   task automatic step(input bit rst, input bit wr, input bit rdy, input logic [1:0] tr,
                       input logic [31:0] addr, input logic [31:0] wd);
      logic [2:0] sel;
      bit         act;
      Hreset = rst; Hwrite = wr; Hreadyin = rdy; Htrans = tr;
      Haddr = addr; Hwdata = wd; Prdata = $urandom;
      #1;
      sel = exp_sel(addr);
      act = rdy && (tr >= 2'd2);
      check("tempselx", {29'd0, tempselx}, {29'd0, sel});
      check("hrdata", Hrdata, Prdata);
      if (m_known)
         check("valid", {31'd0, valid}, {31'd0, act && sel != 0 && m_err_age != 1});
      @(posedge Hclk);
      if (rst) begin
         m_err_age = 0; m_cnt = 0; m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_w = 0;
         m_known = 1;
      end else begin
         if (rdy) begin
            m_a2 = m_a1; m_a1 = addr; m_d2 = m_d1; m_d1 = wd; m_w = wr;
         end
         if (m_err_age == 1) m_err_age = 2;
         else if (act && sel == 0) begin
            m_err_age = 1;
            if (m_cnt < 255) m_cnt++;
         end else m_err_age = 0;
      end
      #1;
      check("haddr1", Haddr1, m_a1);
      check("haddr2", Haddr2, m_a2);
      check("hwdata1", Hwdata1, m_d1);
      check("hwdata2", Hwdata2, m_d2);
      check("hwritereg", {31'd0, Hwritereg}, {31'd0, m_w});
      check("hresp", {30'd0, Hresp}, (m_err_age != 0) ? 32'd1 : 32'd0);
      check("err_stall", {31'd0, err_stall}, {31'd0, m_err_age == 1});
      check("err_count", {24'd0, err_count}, m_cnt);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] bases [8];
      bases = '{32'h8000_0000, 32'h8400_0000, 32'h8800_0000, 32'h8C00_0000,
                32'h7C00_0000, 32'h0000_0000, 32'hFC00_0000, 32'h9000_0000};
      return bases[$urandom_range(0, 7)] | ($urandom & 32'h03FF_FFFC);
   endfunction

   initial begin
      // Reset with random inputs
      step(1, $urandom, $urandom, 2'($urandom), $urandom, $urandom);
      step(1, $urandom, $urandom, 2'($urandom), $urandom, $urandom);
      check("rst_count", {24'd0, err_count}, 32'd0);

      // Single write
      step(0, 1, 1, 2'b10, 32'h8000_0010, 32'h0);
      check("wr_a1", Haddr1, 32'h8000_0010);
      check("wr_w", {31'd0, Hwritereg}, 32'd1);
      step(0, 0, 1, 2'b00, 32'h0, 32'hDEAD_BEEF);
      check("wr_d1", Hwdata1, 32'hDEAD_BEEF);
      check("wr_a2", Haddr2, 32'h8000_0010);

      // Decode boundaries and qualification
      step(0, 0, 1, 2'b10, 32'h8400_0000, 32'h1);
      step(0, 0, 1, 2'b11, 32'h8BFF_FFFC, 32'h2);
      step(0, 0, 1, 2'b01, 32'h8000_0100, 32'h3);
      step(0, 0, 0, 2'b10, 32'h8800_0040, 32'h4);
      check("hold_a1", Haddr1, 32'h8000_0100);
      step(0, 0, 1, 2'b00, 32'h8C00_0000, 32'h5);

      // Single error, then a full recovery
      step(0, 0, 1, 2'b10, 32'h9000_0000, 32'h0);
      check("e1_stall", {31'd0, err_stall}, 32'd1);
      step(0, 0, 1, 2'b00, 32'h0, 32'h0);
      check("e2_resp", {30'd0, Hresp}, 32'd1);
      step(0, 0, 1, 2'b00, 32'h0, 32'h0);
      check("e3_resp", {30'd0, Hresp}, 32'd0);
      check("e3_cnt", {24'd0, err_count}, 32'd1);

      // Back-to-back errors up to saturation
      for (int i = 0; i < 540; i++)
         step(0, 0, 1, 2'b10, 32'hC000_0000 + 32'(i * 4), 32'(i));
      check("sat_cnt", {24'd0, err_count}, 32'd255);

      // Mid-error reset
      step(0, 0, 1, 2'b00, 32'h0, 32'h0);
      step(0, 0, 1, 2'b00, 32'h0, 32'h0);
      step(0, 0, 1, 2'b10, 32'h0000_1000, 32'h0);
      step(1, 0, 1, 2'b10, 32'h8000_0000, 32'h0);
      check("mr_resp", {30'd0, Hresp}, 32'd0);
      check("mr_cnt", {24'd0, err_count}, 32'd0);
      step(0, 1, 1, 2'b10, 32'h8000_0020, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 49) == 0), $urandom, ($urandom_range(0, 4) != 0),
              2'($urandom), rand_addr(), $urandom);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- Upstream neighbour of the APB FSM controller in the AHB-to-APB bridge.
- Samples the AHB address/control/data phases and decodes the target peripheral.
- Produces the `valid`, pipelined address/data, `Hwritereg` and `tempselx` signals the controller consumes.
- Runs a two-cycle AHB ERROR response FSM for unmapped addresses and keeps a saturating error counter.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of peripheral 0 (`tempselx` = 3'b001)
- SLV1_BASE, 32'h8400_0000, base of peripheral 1 (`tempselx` = 3'b010)
- SLV2_BASE, 32'h8800_0000, base of peripheral 2 (`tempselx` = 3'b100)
- REGION_LOG2, 26, log2 of region size in bytes (64 MiB each)
- ERRCNT_W, 8, width of the error counter

Ports:
- Hclk  in  1  bridge clock, all state on rising edge
- Hreset  in  1  synchronous, active-high reset
- Hwrite  in  1  AHB write control (address phase)
- Hreadyin  in  1  AHB HREADY; qualifies address and data phases
- Htrans  in  2  AHB HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- Haddr  in  32  AHB address
- Hwdata  in  32  AHB write data (data phase)
- Prdata  in  32  APB read data
- valid  out  1  combinational: accepted, mapped transfer this cycle
- Haddr1  out  32  address, 1 accepted phase old
- Haddr2  out  32  address, 2 accepted phases old
- Hwdata1  out  32  write data, 1 phase old
- Hwdata2  out  32  write data, 2 phases old
- Hwritereg  out  1  registered Hwrite of last accepted phase
- tempselx  out  3  combinational one-hot decode of Haddr
- Hrdata  out  32  combinational pass-through of Prdata
- Hresp  out  2  registered; 00 OKAY, 01 ERROR
- err_stall  out  1  registered; high only in the first ERROR cycle; top level ANDs its inverse into Hreadyout
- err_count  out  ERRCNT_W  saturating count of ERROR responses issued

Behaviour:
- Reset (Hreset=1 at an edge) clears all of the following to 0 at that edge, regardless of other inputs, including mid-error:
  - Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg
  - Hresp, err_stall, err_count
  - error FSM state (goes to ERR_IDLE)
- Address decode (combinational):
  - hit_n = (Haddr[31:REGION_LOG2] == SLVn_BASE[31:REGION_LOG2]).
  - tempselx = {hit2, hit1, hit0}; 3'b000 when unmapped.
- active = Hreadyin && Htrans[1] (NONSEQ or SEQ). BUSY and IDLE are never active.
- valid = active && |tempselx && (state != ERR_1).
- Pipeline registers, updated only on edges where Hreadyin=1; otherwise they hold:
  - Haddr1 <= Haddr, Haddr2 <= Haddr1
  - Hwdata1 <= Hwdata, Hwdata2 <= Hwdata1
  - Hwritereg <= Hwrite
- Hrdata = Prdata, zero latency.
- Error FSM states: ERR_IDLE, ERR_1, ERR_2.
  - ERR_IDLE: active && tempselx==0 -> ERR_1. Otherwise stay; Hresp=00, err_stall=0.
  - ERR_1: Hresp=01, err_stall=1. Always -> ERR_2. Any address phase in this cycle is ignored.
  - ERR_2: Hresp=01, err_stall=0.
    - active && unmapped -> ERR_1 (back-to-back error).
    - Otherwise -> ERR_IDLE; a mapped active phase here asserts valid normally.
- Hresp/err_stall are driven from the registered state, so an unmapped phase sampled at edge k gives:
  - ERR_1 during cycle k+1 (ERROR, stall)
  - ERR_2 during cycle k+2 (ERROR, no stall)
- err_count increments by 1 on each ERR_1 entry and saturates at all-ones; no wrap-around.
- Simultaneous events: the increment and the back-to-back ERR_2->ERR_1 entry happen on the same edge.

Decomposition:
- Shared package bridge_pkg holds:
  - HTRANS encodings (HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ)
  - HRESP encodings (RESP_OKAY, RESP_ERROR)
  - error FSM state enum
  - one-hot select constants SEL0/SEL1/SEL2
- One natural sub-module, ahb_addr_decode: combinational, parameterised by bases and REGION_LOG2. Outputs tempselx and mapped.

Test Plan:
- Reset: hold Hreset=1 two cycles with random inputs -> every registered output 0, err_count 0, Hresp 00.
- Single write: Htrans=10, Hwrite=1, Haddr=32'h8000_0010, Hreadyin=1; then Hwdata=32'hDEAD_BEEF in the next cycle.
  - Same cycle: valid=1, tempselx=001.
  - Next edge: Haddr1=32'h8000_0010, Hwritereg=1.
  - Following edge: Hwdata1=32'hDEAD_BEEF, Haddr2=32'h8000_0010.
- Decode and qualification:
  - Haddr 32'h8400_0000 -> tempselx 010; Haddr 32'h8BFF_FFFC -> 100; Haddr 32'h8C00_0000 -> 000 with valid=0.
  - Htrans=01 at a mapped address -> valid=0.
  - Hreadyin=0 holds Haddr1 unchanged.
- Error: NONSEQ to 32'h9000_0000 ->
  - cycle+1: Hresp=01, err_stall=1
  - cycle+2: Hresp=01, err_stall=0
  - cycle+3: Hresp=00; err_count=1
- Back-to-back errors: unmapped phase again during ERR_2 -> ERR_1 re-entered, err_count=2. Also force err_count=255 -> stays 255 after a further error.
- Mid-error reset: assert Hreset during ERR_1 -> next cycle Hresp=00, err_stall=0, err_count=0. A mapped phase right after reset gives valid=1.
